coax_framed_rx_buffer: RTL and testbench

Frame-aware receive buffer between the coax word receiver (`coax_rx`) and the host interface. It supersedes the flat word FIFO:
- entries are tagged with an end-of-frame flag;
- a frame becomes visible to the reader only when it completes;
- overflowed or errored frames are rolled back instead of left half-written;
- a latched error can be acknowledged without a full reset.

---
 rtl/coax_framed_rx_buffer.sv | 145 ++++++++++++++
 tb/tb_coax_framed_rx_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coax_framed_rx_buffer.sv
// Frame-aware receive buffer: words become readable only once their frame commits;
// broken frames roll back. Optional `COAX_FRAMED_RX_BUFFER_STATS_EN adds a dropped-frame counter.
module coax_framed_rx_buffer #(
    parameter int DATA_WIDTH        = 10,
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_LEVEL = 12,
    parameter int DISCARD_ON_ERROR  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_active,
    input  logic                         rx_strobe,
    input  logic [DATA_WIDTH-1:0]        rx_data,
    input  logic                         rx_error,
    input  logic                         read_strobe,
    output logic [DATA_WIDTH-1:0]        data,
    output logic                         last,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic [$clog2(DEPTH):0]       level,
    output logic [$clog2(DEPTH):0]       frame_count,
    output logic                         error,
    output logic [1:0]                   error_code,
`ifdef COAX_FRAMED_RX_BUFFER_STATS_EN
    output logic [7:0]                   dropped_frames,
`endif
    output logic [1:0]                   state
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [1:0] ERROR_OVERFLOW = 2'b01;
    localparam logic [1:0] ERROR_RX       = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                state_r;
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic                  mem_last [DEPTH];
    logic [PW-1:0]         wr_ptr, commit_ptr, rd_ptr, frame_count_r;
    logic                  error_r;
    logic [1:0]            error_code_r;

    logic [PW-1:0] occupancy, level_c, wr_next, wr_prev;
    logic          in_rx, ovf, err_ev, wr_en, commit, commit_frame, rollback;
    logic          pop, ack, pop_last;

    assign occupancy = wr_ptr - rd_ptr;
    assign level_c   = commit_ptr - rd_ptr;
    assign wr_next   = wr_ptr + PW'(wr_en);
    assign wr_prev   = wr_ptr - PW'(1);

    assign in_rx  = (state_r == RECEIVE);
    assign ovf    = in_rx && rx_strobe && full;
    assign err_ev = in_rx && !ovf && rx_error;
    // With discard-on-error a strobe that coincides with the error belongs to the dropped frame.
    assign wr_en  = in_rx && rx_strobe && !full && !(err_ev && DISCARD_ON_ERROR != 0);
    assign commit = in_rx && !ovf && (err_ev ? (DISCARD_ON_ERROR == 0) : !rx_active);
    assign commit_frame = commit && (wr_en || (wr_ptr != commit_ptr));
    assign rollback     = ovf || (err_ev && DISCARD_ON_ERROR != 0);

    assign pop      = read_strobe && !error_r && !empty;
    assign ack      = read_strobe && error_r;
    assign pop_last = pop && mem_last[rd_ptr[AW-1:0]];

    assign full        = (occupancy == PW'(DEPTH));
    assign level       = level_c;
    assign empty       = (level_c == '0);
    assign almost_full = (level_c >= PW'(ALMOST_FULL_LEVEL));
    assign frame_count = frame_count_r;
    assign error       = error_r;
    assign error_code  = error_code_r;
    assign state       = state_r;
    assign last        = !empty && mem_last[rd_ptr[AW-1:0]];

    always_comb begin
        data = '0;
        if (error_r)
            data = {{(DATA_WIDTH-2){1'b0}}, error_code_r};
        else if (!empty)
            data = mem_data[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr[AW-1:0]] <= rx_data;
            mem_last[wr_ptr[AW-1:0]] <= commit;
        end else if (commit_frame) begin
            mem_last[wr_prev[AW-1:0]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            rd_ptr        <= '0;
            frame_count_r <= '0;
            error_r       <= 1'b0;
            error_code_r  <= 2'b00;
        end else begin
            case (state_r)
                IDLE:    if (rx_active) state_r <= RECEIVE;
                RECEIVE: begin
                    if (ovf || err_ev)  state_r <= DISCARD;
                    else if (!rx_active) state_r <= IDLE;
                end
                DISCARD: if (!rx_active) state_r <= IDLE;
                default: state_r <= IDLE;
            endcase

            wr_ptr <= rollback ? commit_ptr : wr_next;
            if (commit_frame) commit_ptr <= wr_next;
            if (pop)          rd_ptr     <= rd_ptr + PW'(1);
            frame_count_r <= frame_count_r + PW'(commit_frame) - PW'(pop_last);

            // Acknowledge first so an error arriving in the same cycle is not lost.
            if (ack) begin
                error_r      <= 1'b0;
                error_code_r <= 2'b00;
            end
            if ((ovf || err_ev) && (!error_r || ack)) begin
                error_r      <= 1'b1;
                error_code_r <= ovf ? ERROR_OVERFLOW : ERROR_RX;
            end
        end
    end

`ifdef COAX_FRAMED_RX_BUFFER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            dropped_frames <= '0;
        else if (rollback && dropped_frames != 8'hFF)
            dropped_frames <= dropped_frames + 8'd1;
    end
`endif

endmodule

// File: tb/tb_coax_framed_rx_buffer.sv
// Directed bench for coax_framed_rx_buffer: popped words are checked against an
// expected queue by a monitor; status flags are checked inline after each step.
module tb_coax_framed_rx_buffer;

    localparam int DW  = 10;
    localparam int DEP = 8;
    localparam int AFL = 6;
    localparam int LW  = $clog2(DEP) + 1;

    logic          clk = 1'b0;
    logic          reset, rx_active, rx_strobe, rx_error, read_strobe, rd0;
    logic [DW-1:0] rx_data;

    logic [DW-1:0] data, data_0;
    logic          last, empty, full, almost_full, error;
    logic          last_0, empty_0, full_0, almost_full_0, error_0;
    logic [LW-1:0] level, frame_count, level_0, frame_count_0;
    logic [1:0]    error_code, error_code_0, state, state_0;
`ifdef COAX_FRAMED_RX_BUFFER_STATS_EN
    logic [7:0]    dropped_frames, dropped_frames_0;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [DW:0] exp_q[$];

    always #5 clk = ~clk;

    coax_framed_rx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEP), .ALMOST_FULL_LEVEL(AFL),
                            .DISCARD_ON_ERROR(1)) dut (
        .clk(clk), .reset(reset), .rx_active(rx_active), .rx_strobe(rx_strobe),
        .rx_data(rx_data), .rx_error(rx_error), .read_strobe(read_strobe),
        .data(data), .last(last), .empty(empty), .full(full), .almost_full(almost_full),
        .level(level), .frame_count(frame_count), .error(error), .error_code(error_code),
`ifdef COAX_FRAMED_RX_BUFFER_STATS_EN
        .dropped_frames(dropped_frames),
`endif
        .state(state));

    coax_framed_rx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEP), .ALMOST_FULL_LEVEL(AFL),
                            .DISCARD_ON_ERROR(0)) dut0 (
        .clk(clk), .reset(reset), .rx_active(rx_active), .rx_strobe(rx_strobe),
        .rx_data(rx_data), .rx_error(rx_error), .read_strobe(rd0),
        .data(data_0), .last(last_0), .empty(empty_0), .full(full_0),
        .almost_full(almost_full_0), .level(level_0), .frame_count(frame_count_0),
        .error(error_0), .error_code(error_code_0),
`ifdef COAX_FRAMED_RX_BUFFER_STATS_EN
        .dropped_frames(dropped_frames_0),
`endif
        .state(state_0));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"}, 32'(data), 0);
        chk({tag, "_last"}, 32'(last), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_af"}, 32'(almost_full), 0);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_fc"}, 32'(frame_count), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_code"}, 32'(error_code), 0);
        chk({tag, "_state"}, 32'(state), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One frame of n words base+i; optionally the final strobe lands on rx_active falling.
    task automatic send_frame(input int n, input logic [DW-1:0] base,
                              input bit strobe_on_fall, input bit expect_commit);
        if (expect_commit)
            for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), DW'(base + DW'(i))});
        rx_active = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            if (strobe_on_fall && i == n - 1) rx_active = 1'b0;
            rx_strobe = 1'b1;
            rx_data   = base + DW'(i);
            tick();
        end
        rx_strobe = 1'b0;
        rx_active = 1'b0;
        tick();
    endtask

    task automatic read_n(input int n);
        read_strobe = 1'b1;
        for (int i = 0; i < n; i++) tick();
        read_strobe = 1'b0;
    endtask

    // Monitor: each accepted pop is compared against the queue head.
    always @(negedge clk) begin
        if (!reset && read_strobe && !error && !empty) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got last=%0b data=%0h, expected no word", last, data);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                if ({last, data} !== e) begin
                    miscompares++;
                    $display("FAIL pop_word: got last=%0b data=%0h, expected last=%0b data=%0h",
                             last, data, e[DW], e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rx_active = 1'b0; rx_strobe = 1'b0; rx_error = 1'b0;
        rx_data = '0; read_strobe = 1'b0; rd0 = 1'b0;
        do_reset();
        tick();
        chk_reset_vals("rst");

        // 1: fill with one 8-word frame, drain it
        send_frame(8, 10'h167, 0, 1);
        chk("s1_full", 32'(full), 1);
        chk("s1_empty", 32'(empty), 0);
        chk("s1_level", 32'(level), 8);
        chk("s1_fc", 32'(frame_count), 1);
        chk("s1_error", 32'(error), 0);
        read_n(8);
        chk("s1_empty_after", 32'(empty), 1);
        chk("s1_full_after", 32'(full), 0);
        chk("s1_fc_after", 32'(frame_count), 0);

        // 2: second frame overflows and is rolled back
        send_frame(4, 10'h010, 0, 1);
        send_frame(5, 10'h020, 0, 0);
        chk("s2_error", 32'(error), 1);
        chk("s2_code", 32'(error_code), 1);
        chk("s2_data", 32'(data), 1);
        chk("s2_level", 32'(level), 4);
        chk("s2_fc", 32'(frame_count), 1);
        chk("s2_full", 32'(full), 0);
        chk("s2_state", 32'(state), 0);
`ifdef COAX_FRAMED_RX_BUFFER_STATS_EN
        chk("s2_dropped", 32'(dropped_frames), 1);
`endif
        read_n(1);
        chk("s2_ack_error", 32'(error), 0);
        chk("s2_ack_level", 32'(level), 4);
        read_n(4);
        chk("s2_empty_after", 32'(empty), 1);

        // 3: rx_error after 3 words, both error policies
        do_reset();
        rx_active = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            rx_strobe = 1'b1;
            rx_data   = 10'h0A0 + DW'(i);
            tick();
        end
        rx_strobe = 1'b0;
        rx_error  = 1'b1;
        tick();
        rx_error  = 1'b0;
        rx_active = 1'b0;
        tick();
        chk("s3_empty", 32'(empty), 1);
        chk("s3_level", 32'(level), 0);
        chk("s3_code", 32'(error_code), 2);
        chk("s3k_level", 32'(level_0), 3);
        chk("s3k_fc", 32'(frame_count_0), 1);
        chk("s3k_code", 32'(error_code_0), 2);
        read_strobe = 1'b1; rd0 = 1'b1;
        tick();
        read_strobe = 1'b0; rd0 = 1'b0;
        chk("s3_ack", 32'(error), 0);
        chk("s3k_ack", 32'(error_0), 0);
        for (int i = 0; i < 3; i++) begin
            chk("s3k_data", 32'(data_0), 32'(10'h0A0 + i));
            chk("s3k_last", 32'(last_0), (i == 2) ? 1 : 0);
            rd0 = 1'b1;
            tick();
            rd0 = 1'b0;
        end
        chk("s3k_empty_after", 32'(empty_0), 1);
        chk("s3k_fc_after", 32'(frame_count_0), 0);

        // 4: empty rx_active pulse, then strobe on the falling edge of rx_active
        rx_active = 1'b1;
        tick();
        tick();
        rx_active = 1'b0;
        tick();
        chk("s4_fc_empty_frame", 32'(frame_count), 0);
        chk("s4_empty", 32'(empty), 1);
        send_frame(2, 10'h0C0, 1, 1);
        chk("s4_level", 32'(level), 2);
        chk("s4_fc", 32'(frame_count), 1);
        read_n(2);
        chk("s4_fc_after", 32'(frame_count), 0);

        // 5: streaming at level 4 with overlapping pops, commit and last-pop
        send_frame(4, 10'h040, 0, 1);
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), DW'(10'h050 + i)});
        rx_active = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            rx_strobe   = 1'b1;
            rx_data     = 10'h050 + DW'(i);
            read_strobe = 1'b1;
            if (i == 3) rx_active = 1'b0;
            tick();
            if (i == 2) begin
                chk("s5_level_mid", 32'(level), 1);
                chk("s5_fc_mid", 32'(frame_count), 1);
                chk("s5_full_mid", 32'(full), 0);
            end
        end
        rx_strobe = 1'b0; read_strobe = 1'b0;
        tick();
        chk("s5_level_held", 32'(level), 4);
        chk("s5_fc_held", 32'(frame_count), 1);
        chk("s5_af_4", 32'(almost_full), 0);
        send_frame(1, 10'h060, 0, 1);
        chk("s5_af_5", 32'(almost_full), 0);
        send_frame(1, 10'h070, 0, 1);
        chk("s5_level_6", 32'(level), 6);
        chk("s5_af_6", 32'(almost_full), 1);
        read_n(1);
        chk("s5_af_back_5", 32'(almost_full), 0);
        read_n(5);
        chk("s5_empty_after", 32'(empty), 1);

        // 6: reset mid-frame, then a clean frame
        rx_active = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            rx_strobe = 1'b1;
            rx_data   = 10'h0E0 + DW'(i);
            tick();
        end
        rx_strobe = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("s6");
        tick();
        chk("s6_state_receive", 32'(state), 1);
        send_frame(3, 10'h0F0, 0, 1);
        chk("s6_level", 32'(level), 3);
        chk("s6_fc", 32'(frame_count), 1);
        read_n(3);
        chk("s6_empty_after", 32'(empty), 1);

        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
